// File: rtl/cordic_rotation_engine.sv
// Iterative rotation-mode CORDIC: rotates (x_in,y_in) by angle_in with one micro-rotation per cycle.
// Results carry the uncompensated CORDIC gain K (~1.64676); angles are binary (2^WIDTH = 360 deg).
module cordic_rotation_engine #(
   parameter int WIDTH = 32,
   parameter int ITER  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] angle_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] angle_res
);
   localparam int IW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] QUARTER = {2'b01, {(WIDTH-2){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_FINISH} state_t;

   state_t                  state;
   logic signed [WIDTH-1:0] x, y, z;
   logic        [IW-1:0]    i;
   logic signed [WIDTH-1:0] xs, ys;
   logic        [WIDTH-1:0] atan_i;

   // atan(2^-i) in 32-bit binary angle, top-aligned onto WIDTH bits
   function automatic logic [WIDTH-1:0] atan_lut(input logic [IW-1:0] idx);
      logic [31:0] c;
      logic [63:0] w;
      case (int'(idx))
         0:  c = 32'h2000_0000;
         1:  c = 32'h12E4_051E;
         2:  c = 32'h09FB_385B;
         3:  c = 32'h0511_11D4;
         4:  c = 32'h028B_0D43;
         5:  c = 32'h0145_D7E1;
         6:  c = 32'h00A2_F61E;
         7:  c = 32'h0051_7C55;
         8:  c = 32'h0028_BE53;
         9:  c = 32'h0014_5F2F;
         10: c = 32'h000A_2F98;
         11: c = 32'h0005_17CC;
         12: c = 32'h0002_8BE6;
         13: c = 32'h0001_45F3;
         14: c = 32'h0000_A2FA;
         15: c = 32'h0000_517D;
         16: c = 32'h0000_28BE;
         17: c = 32'h0000_145F;
         18: c = 32'h0000_0A30;
         19: c = 32'h0000_0518;
         20: c = 32'h0000_028C;
         21: c = 32'h0000_0146;
         22: c = 32'h0000_00A3;
         23: c = 32'h0000_0051;
         24: c = 32'h0000_0029;
         25: c = 32'h0000_0014;
         26: c = 32'h0000_000A;
         27: c = 32'h0000_0005;
         28: c = 32'h0000_0003;
         29: c = 32'h0000_0001;
         default: c = 32'h0000_0000;
      endcase
      w = {c, 32'd0};
      return w[63 -: WIDTH];
   endfunction

   assign xs     = x >>> i;
   assign ys     = y >>> i;
   assign atan_i = atan_lut(i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         x_out     <= '0;
         y_out     <= '0;
         angle_res <= '0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         i         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // the done cycle is spent in IDLE, so a start seen alongside done is dropped
               if (start && !done) begin
                  case (angle_in[WIDTH-1:WIDTH-2])
                     2'b01: begin
                        x <= -$signed(y_in);
                        y <= $signed(x_in);
                        z <= $signed(angle_in - QUARTER);
                     end
                     2'b10: begin
                        x <= $signed(y_in);
                        y <= -$signed(x_in);
                        z <= $signed(angle_in + QUARTER);
                     end
                     default: begin
                        x <= $signed(x_in);
                        y <= $signed(y_in);
                        z <= $signed(angle_in);
                     end
                  endcase
                  i     <= '0;
                  busy  <= 1'b1;
                  state <= S_ROTATE;
               end
            end
            S_ROTATE: begin
               if (!z[WIDTH-1]) begin
                  x <= x - ys;
                  y <= y + xs;
                  z <= z - $signed(atan_i);
               end else begin
                  x <= x + ys;
                  y <= y - xs;
                  z <= z + $signed(atan_i);
               end
               i <= i + 1'b1;
               if (i == IW'(ITER - 1))
                  state <= S_FINISH;
            end
            S_FINISH: begin
               x_out     <= x;
               y_out     <= y;
               angle_res <= z;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Bench for cordic_rotation_engine: directed quadrant cases, random rotations against a
// floating-point rotation model, ignored starts, mid-operation reset and back-to-back starts.
module tb_cordic_rotation_engine;
   localparam int WIDTH = 32;
   localparam int ITER  = 16;
   localparam real PI   = 3.14159265358979323846;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] x_in, y_in, angle_in;
   logic             busy, done;
   logic [WIDTH-1:0] x_out, y_out, angle_res;

   int  tests = 0;
   int  fails = 0;
   real kgain;

   cordic_rotation_engine #(.WIDTH(WIDTH), .ITER(ITER)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
      .busy(busy), .done(done),
      .x_out(x_out), .y_out(y_out), .angle_res(angle_res)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic real rabs(input real v);
      return (v < 0.0) ? -v : v;
   endfunction

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input logic signed [WIDTH-1:0] obs, input real exp);
      tests++;
      assert (rabs($itor(obs) - exp) <= 16384.0) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0.1f", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic signed [WIDTH-1:0] obs);
      tests++;
      assert (rabs($itor(obs)) < 131072.0) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=|res|<131072", tag, obs);
      end
   endtask

   // Ideal rotation by the angle in radians, scaled by the CORDIC gain
   task automatic model(input logic signed [WIDTH-1:0] x, input logic signed [WIDTH-1:0] y,
                        input logic signed [WIDTH-1:0] a, output real ex, output real ey);
      real th;
      th = $itor(a) * 2.0 * PI / 4294967296.0;
      ex = kgain * ($itor(x) * $cos(th) - $itor(y) * $sin(th));
      ey = kgain * ($itor(x) * $sin(th) + $itor(y) * $cos(th));
   endtask

   task automatic run_and_check(input string tag, input logic [WIDTH-1:0] x,
                                input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] a);
      int  k;
      real ex, ey;
      x_in = x; y_in = y; angle_in = a; start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      chk({tag, "_latency"}, WIDTH'(k), WIDTH'(ITER + 1));
      model(x, y, a, ex, ey);
      chk_tol({tag, "_x"}, x_out, ex);
      chk_tol({tag, "_y"}, y_out, ey);
      chk_res({tag, "_res"}, angle_res);
      chk({tag, "_busy_at_done"}, WIDTH'(busy), 0);
      tick();
   endtask

   initial begin
      int          dones, rises, done_k;
      logic        bprev;
      logic [31:0] rx, ry;

      kgain = 1.0;
      for (int n = 0; n < ITER; n++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * n));

      rst_n = 1'b0; start = 1'b0; x_in = '0; y_in = '0; angle_in = '0;
      tick(); tick();
      chk("rst_busy", WIDTH'(busy), 0);
      chk("rst_done", WIDTH'(done), 0);
      chk("rst_x", x_out, 0);
      chk("rst_y", y_out, 0);
      chk("rst_res", angle_res, 0);
      rst_n = 1'b1;
      tick();

      run_and_check("a0",   32'h1000_0000, 32'h0, 32'h0000_0000);
      run_and_check("a90",  32'h1000_0000, 32'h0, 32'h4000_0000);
      run_and_check("a180", 32'h1000_0000, 32'h0, 32'h8000_0000);
      run_and_check("am90", 32'h1000_0000, 32'h0, 32'hC000_0000);
      run_and_check("a45",  32'h1000_0000, 32'h0, 32'h2000_0000);

      for (int r = 0; r < 20; r++) begin
         rx = 32'($urandom_range(0, 268435455)) - 32'd134217728;
         ry = 32'($urandom_range(0, 268435455)) - 32'd134217728;
         run_and_check($sformatf("rnd%0d", r), rx, ry, $urandom);
      end

      // Starts in cycles 3 and 16 of an operation must be dropped
      x_in = 32'h0800_0000; y_in = 32'hFC00_0000; angle_in = 32'h1234_5678; start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0; rises = 0; done_k = -1; bprev = busy;
      for (int k = 1; k <= 30; k++) begin
         start = (k == 3 || k == 16);
         tick();
         if (done) begin dones++; done_k = k; end
         if (busy && !bprev) rises++;
         bprev = busy;
      end
      start = 1'b0;
      chk("ign_done_count", WIDTH'(dones), 1);
      chk("ign_done_cycle", WIDTH'(done_k), WIDTH'(ITER + 1));
      chk("ign_busy_rises", WIDTH'(rises), 0);
      chk("ign_idle_after", WIDTH'(busy), 0);

      // Reset during iteration 8 aborts with no done pulse
      x_in = 32'h0700_0000; y_in = 32'h0300_0000; angle_in = 32'h3000_0000; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", WIDTH'(busy), 0);
      chk("abort_done", WIDTH'(done), 0);
      chk("abort_x", x_out, 0);
      chk("abort_y", y_out, 0);
      chk("abort_res", angle_res, 0);
      tick(); tick();
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (done) dones++;
      end
      chk("abort_no_done", WIDTH'(dones), 0);
      run_and_check("after_abort", 32'h0700_0000, 32'h0300_0000, 32'h3000_0000);

      // Start held high runs operations back to back
      x_in = 32'h0400_0000; y_in = 32'h0200_0000; angle_in = 32'hA000_0000; start = 1'b1;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done) dones++;
      end
      start = 1'b0;
      chk("b2b_done_count", WIDTH'(dones), 2);
      begin
         real ex, ey;
         model(32'h0400_0000, 32'h0200_0000, 32'hA000_0000, ex, ey);
         chk_tol("b2b_x", x_out, ex);
         chk_tol("b2b_y", y_out, ey);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
